mem_io_responder: RTL and testbench

// - Memory/I/O-side responder for the CPU byte bus: decodes address, write strobe and write data; returns read data one cycle later.
// - Holds the 128 KB program/data RAM plus the memory-mapped I/O: UART TX queue, RX input queue, cycle counter, program-stop.
// - Drives the buffer-full flag the CPU throttles I/O writes on. Sits between the cpu top and the UART/host link.

---
 rtl/mem_io_responder_pkg.sv | 19 +
 rtl/mem_io_responder_if.sv | 14 +
 rtl/mem_io_responder_fifo.sv | 50 +++++
 rtl/mem_io_responder.sv | 121 ++++++++++++
 tb/tb_mem_io_responder.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared address map and decode helper for the memory/I/O responder.
package mem_io_pkg;

    localparam logic [17:0] IO_BASE  = 18'h30000;
    localparam logic [1:0]  IO_UART  = 2'h0;
    localparam logic [1:0]  IO_CLOCK = 2'h1;

    typedef enum logic [1:0] {SEL_RAM, SEL_UART, SEL_CLOCK, SEL_NONE} ioSel_t;

    // Only bits 17:0 take part in decode; UART is a single byte, the clock a dword.
    function automatic ioSel_t decodeAddr(input logic [17:0] addr);
        if (addr[17:16] != IO_BASE[17:16]) return SEL_RAM;
        if (addr[15:4] != IO_BASE[15:4]) return SEL_NONE;
        if (addr[3:2] == IO_UART) return (addr[1:0] == 2'b00) ? SEL_UART : SEL_NONE;
        if (addr[3:2] == IO_CLOCK) return SEL_CLOCK;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus between the cpu top (master) and the memory/I/O responder (slave).
interface mem_io_responder_if;
    logic        readyIn;
    logic [31:0] cpuAddr;
    logic        cpuWrite;
    logic [7:0]  cpuDataIn;
    logic [7:0]  cpuDataOut;
    logic        ioBufferFull;

    modport master (output readyIn, cpuAddr, cpuWrite, cpuDataIn,
                    input  cpuDataOut, ioBufferFull);
    modport slave  (input  readyIn, cpuAddr, cpuWrite, cpuDataIn,
                    output cpuDataOut, ioBufferFull);
endinterface

// File: rtl/mem_io_responder_fifo.sv
// Byte FIFO with combinational head; a push on a full FIFO is taken when a pop happens the same cycle.
module byte_fifo #(
    parameter int FIFO_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [7:0]          pushData,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [FIFO_WIDTH:0] count,
    output logic [FIFO_WIDTH:0] countNext,
    output logic [7:0]          head
);
    localparam logic [FIFO_WIDTH:0] DEPTH = (FIFO_WIDTH+1)'(2**FIFO_WIDTH);
    localparam logic [FIFO_WIDTH:0] ONE   = (FIFO_WIDTH+1)'(1);

    logic [7:0]            mem [2**FIFO_WIDTH];
    logic [FIFO_WIDTH-1:0] wrPtr, rdPtr;
    logic                  doPush, doPop;

    assign full   = (count == DEPTH);
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    always_comb begin
        countNext = count;
        if (doPush && !doPop) countNext = count + ONE;
        else if (doPop && !doPush) countNext = count - ONE;
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= countNext;
        end
    end
endmodule

// File: rtl/mem_io_responder.sv
// Memory/I/O responder: program RAM, UART TX/RX queues, free-running cycle counter, program-stop flag.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int FIFO_WIDTH     = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic                clockIn,
    input  logic                resetIn,
    mem_io_responder_if.slave   bus,
    output logic                txValid,
    output logic [7:0]          txData,
    input  logic                txReady,
    input  logic                rxValid,
    input  logic [7:0]          rxData,
    output logic                rxReady,
    output logic                programDone,
    output logic                txOverflow
);
    localparam int DEPTH = 2**FIFO_WIDTH;

    logic [7:0]  ram [2**RAM_ADDR_WIDTH];
    logic [7:0]  ramRd, ioRd;
    logic        outRam;
    logic [31:0] counter;
    logic [31:8] cntLatch;

    ioSel_t      sel;
    logic [1:0]  byteSel;
    logic        cpuRd, cpuWr;
    logic        txPush, txPop, txFull, txEmpty;
    logic [7:0]  txPushData;
    logic        rxPop, rxFull, rxEmpty;
    logic [7:0]  rxHead;
    logic [FIFO_WIDTH:0] txCount, txCountNext, rxCount, rxCountNext;
    logic        unusedBits;

    assign sel     = decodeAddr(bus.cpuAddr[17:0]);
    assign byteSel = bus.cpuAddr[1:0];
    assign cpuRd   = bus.readyIn && !bus.cpuWrite;
    assign cpuWr   = bus.readyIn && bus.cpuWrite;

    // A zero byte written to the UART is a no-op; the stop write queues the 0x00 terminator.
    assign txPush     = cpuWr && ((sel == SEL_UART && bus.cpuDataIn != 8'h00) ||
                                  (sel == SEL_CLOCK && byteSel == 2'd0));
    assign txPushData = (sel == SEL_UART) ? bus.cpuDataIn : 8'h00;
    assign txPop      = txValid && txReady;
    assign txValid    = !txEmpty;
    assign rxPop      = cpuRd && sel == SEL_UART && !rxEmpty;
    assign rxReady    = !rxFull;
    assign unusedBits = ^{bus.cpuAddr[31:18], txCount, rxCount, rxCountNext};

    byte_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) txFifo (
        .clk(clockIn), .rst(resetIn), .push(txPush), .pushData(txPushData), .pop(txPop),
        .full(txFull), .empty(txEmpty), .count(txCount), .countNext(txCountNext), .head(txData)
    );

    byte_fifo #(.FIFO_WIDTH(FIFO_WIDTH)) rxFifo (
        .clk(clockIn), .rst(resetIn), .push(rxValid), .pushData(rxData), .pop(rxPop),
        .full(rxFull), .empty(rxEmpty), .count(rxCount), .countNext(rxCountNext), .head(rxHead)
    );

    // Kept free of reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clockIn) begin
        if (bus.readyIn && sel == SEL_RAM) begin
            if (bus.cpuWrite) ram[bus.cpuAddr[RAM_ADDR_WIDTH-1:0]] <= bus.cpuDataIn;
            else              ramRd <= ram[bus.cpuAddr[RAM_ADDR_WIDTH-1:0]];
        end
    end

    assign bus.cpuDataOut = outRam ? ramRd : ioRd;

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            outRam           <= 1'b0;
            ioRd             <= 8'h00;
            cntLatch         <= '0;
            counter          <= 32'd0;
            programDone      <= 1'b0;
            txOverflow       <= 1'b0;
            bus.ioBufferFull <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            // Based on next count so the flag already covers the write landing this cycle.
            bus.ioBufferFull <= (DEPTH - int'(txCountNext)) <= FULL_MARGIN;
            if (txPush && txFull && !txPop) txOverflow <= 1'b1;
            if (bus.readyIn) begin
                case (sel)
                    SEL_RAM: if (!bus.cpuWrite) outRam <= 1'b1;
                    SEL_UART: begin
                        outRam <= 1'b0;
                        ioRd   <= rxPop ? rxHead : 8'h00;
                    end
                    SEL_CLOCK: begin
                        outRam <= 1'b0;
                        ioRd   <= 8'h00;
                        if (bus.cpuWrite) begin
                            if (byteSel == 2'd0) programDone <= 1'b1;
                        end else begin
                            // Byte 0 snapshots the counter so the upper bytes read back coherently.
                            case (byteSel)
                                2'd0: begin
                                    ioRd     <= counter[7:0];
                                    cntLatch <= counter[31:8];
                                end
                                2'd1: ioRd <= cntLatch[15:8];
                                2'd2: ioRd <= cntLatch[23:16];
                                2'd3: ioRd <= cntLatch[31:24];
                            endcase
                        end
                    end
                    default: begin
                        outRam <= 1'b0;
                        ioRd   <= 8'h00;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM latency, TX/RX queues, counter coherence, reset.
module tb_mem_io_responder;
    logic       clk = 1'b0;
    logic       rst;
    logic       txValid, txReady, rxValid, rxReady, programDone, txOverflow;
    logic [7:0] txData, rxData;
    int         checks = 0;
    int         errors = 0;
    int         cyc;
    int         guard;

    mem_io_responder_if bus ();

    mem_io_responder dut (
        .clockIn(clk), .resetIn(rst), .bus(bus),
        .txValid(txValid), .txData(txData), .txReady(txReady),
        .rxValid(rxValid), .rxData(rxData), .rxReady(rxReady),
        .programDone(programDone), .txOverflow(txOverflow)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the DUT counter must equal this.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus request just after a falling edge and wait for the next falling edge.
    task automatic step(input logic rdy, input logic [31:0] a, input logic w, input logic [7:0] d);
        bus.readyIn   = rdy;
        bus.cpuAddr   = a;
        bus.cpuWrite  = w;
        bus.cpuDataIn = d;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        txReady = 1'b0; rxValid = 1'b0; rxData = 8'h00;
        bus.readyIn = 1'b0; bus.cpuAddr = 32'h0; bus.cpuWrite = 1'b0; bus.cpuDataIn = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_dout", bus.cpuDataOut, 8'h00);
        chk("rst_txValid", txValid, 1'b0);
        chk("rst_rxReady", rxReady, 1'b1);
        chk("rst_bufFull", bus.ioBufferFull, 1'b0);
        chk("rst_progDone", programDone, 1'b0);
        chk("rst_txOvf", txOverflow, 1'b0);
        rst = 1'b0;

        // RAM write then read, latency one cycle; writes and stalled cycles hold the output.
        step(1'b1, 32'h00010, 1'b1, 8'hA5);
        chk("ram_wr_hold", bus.cpuDataOut, 8'h00);
        step(1'b1, 32'h00010, 1'b0, 8'h00);
        chk("ram_rd_a5", bus.cpuDataOut, 8'hA5);
        step(1'b1, 32'h1FFFF, 1'b1, 8'h3C);
        chk("ram_wr_hold2", bus.cpuDataOut, 8'hA5);
        step(1'b0, 32'h00010, 1'b1, 8'h77);
        chk("ram_stall_hold", bus.cpuDataOut, 8'hA5);
        step(1'b1, 32'h1FFFF, 1'b0, 8'h00);
        chk("ram_rd_top", bus.cpuDataOut, 8'h3C);
        step(1'b1, 32'h00010, 1'b0, 8'h00);
        chk("ram_stall_nowr", bus.cpuDataOut, 8'hA5);

        // UART TX: zero byte is filtered out.
        step(1'b1, 32'h30000, 1'b1, 8'h41);
        step(1'b1, 32'h30000, 1'b1, 8'h00);
        step(1'b1, 32'h30000, 1'b1, 8'h42);
        chk("tx_valid1", txValid, 1'b1);
        chk("tx_data41", txData, 8'h41);
        txReady = 1'b1;
        idle();
        chk("tx_data42", txData, 8'h42);
        idle();
        chk("tx_drained", txValid, 1'b0);
        chk("tx_noOvf", txOverflow, 1'b0);
        txReady = 1'b0;

        // Fill TX: near-full after the 6th byte, 9th byte dropped.
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 32'h30000, 1'b1, 8'(i));
            if (i == 5) chk("fill5_bufFull", bus.ioBufferFull, 1'b0);
            if (i == 6) chk("fill6_bufFull", bus.ioBufferFull, 1'b1);
            if (i == 8) chk("fill8_ovf", txOverflow, 1'b0);
            if (i == 9) chk("fill9_ovf", txOverflow, 1'b1);
        end
        txReady = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", txValid, 1'b1);
            chk("drain_data", txData, 32'(i));
            idle();
        end
        chk("drain_empty", txValid, 1'b0);
        chk("drain_bufFull", bus.ioBufferFull, 1'b0);
        txReady = 1'b0;

        // Counter at 100 edges after reset; upper bytes come from the snapshot.
        guard = 0;
        while (cyc < 100 && guard < 2000) begin idle(); guard++; end
        chk("cnt_align100", cyc, 100);
        step(1'b1, 32'h30004, 1'b0, 8'h00);
        chk("cnt100_b0", bus.cpuDataOut, 8'd100);
        step(1'b1, 32'h30005, 1'b0, 8'h00);
        chk("cnt100_b1", bus.cpuDataOut, 8'h00);
        step(1'b1, 32'h30006, 1'b0, 8'h00);
        chk("cnt100_b2", bus.cpuDataOut, 8'h00);
        step(1'b1, 32'h30007, 1'b0, 8'h00);
        chk("cnt100_b3", bus.cpuDataOut, 8'h00);

        // RX: empty read gives zero, one offered byte is read back, then empty again.
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        chk("rx_empty_rd", bus.cpuDataOut, 8'h00);
        rxValid = 1'b1; rxData = 8'h37;
        idle();
        rxValid = 1'b0;
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        chk("rx_rd37", bus.cpuDataOut, 8'h37);
        step(1'b1, 32'h30000, 1'b0, 8'h00);
        chk("rx_empty_again", bus.cpuDataOut, 8'h00);

        // Counter read across a byte carry: live bytes would tear, the snapshot must not.
        guard = 0;
        while (cyc < 511 && guard < 2000) begin idle(); guard++; end
        chk("cnt_align511", cyc, 511);
        step(1'b1, 32'h30004, 1'b0, 8'h00);
        chk("cnt511_b0", bus.cpuDataOut, 8'hFF);
        step(1'b1, 32'h30005, 1'b0, 8'h00);
        chk("cnt511_b1", bus.cpuDataOut, 8'h01);
        step(1'b1, 32'h30006, 1'b0, 8'h00);
        chk("cnt511_b2", bus.cpuDataOut, 8'h00);
        step(1'b1, 32'h30001, 1'b0, 8'h00);
        chk("io_other_rd", bus.cpuDataOut, 8'h00);

        // Fill RX until it refuses more.
        rxValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rxData = 8'(8'h50 + i);
            idle();
        end
        rxValid = 1'b0;
        chk("rx_full", rxReady, 1'b0);

        // Program stop queues 0x00 behind pending TX; reset mid-drain clears everything at once.
        step(1'b1, 32'h30000, 1'b1, 8'h11);
        step(1'b1, 32'h30004, 1'b1, 8'h55);
        idle();
        chk("stop_done", programDone, 1'b1);
        chk("stop_head11", txData, 8'h11);
        txReady = 1'b1;
        idle();
        chk("stop_head00", txData, 8'h00);
        chk("stop_valid", txValid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_txValid", txValid, 1'b0);
        chk("arst_progDone", programDone, 1'b0);
        chk("arst_txOvf", txOverflow, 1'b0);
        chk("arst_rxReady", rxReady, 1'b1);
        chk("arst_dout", bus.cpuDataOut, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        txReady = 1'b0;
        step(1'b1, 32'h00010, 1'b0, 8'h00);
        chk("ram_survives_rst", bus.cpuDataOut, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
